// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the packet round-robin scheduler.
package fifo_sched_pkg;

  typedef enum logic {IDLE, XFER} sched_state_t;

  localparam int PKT_CNT_WIDTH = 16;

endpackage

// File: rtl/pkt_rr_scheduler_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr_i.
module rr_pick #(
  parameter int P_N     = 4,
  parameter int P_IDX_W = 2
) (
  input  logic [P_N-1:0]     req_i,
  input  logic [P_IDX_W-1:0] ptr_i,
  output logic               found_o,
  output logic [P_IDX_W-1:0] idx_o
);

  int unsigned w_k;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    w_k     = 0;
    for (int unsigned i = 0; i < P_N; i++) begin
      w_k = (32'(ptr_i) + i) % P_N;
      if (!found_o && req_i[w_k]) begin
        found_o = 1'b1;
        idx_o   = P_IDX_W'(w_k);
      end
    end
  end

endmodule

// File: rtl/pkt_rr_scheduler.sv
// Packet-granular round-robin drain of P_NUM_PORTS FWFT FIFOs onto one
// valid/ready stream, with starvation detection and a packet counter.
module pkt_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int P_NUM_PORTS    = 4,
  parameter int P_DATA_WIDTH   = 32,
  parameter int P_STALL_CYCLES = 255
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  en_i,
  input  logic [P_NUM_PORTS-1:0]                fifo_empty_i,
  input  logic [P_NUM_PORTS*P_DATA_WIDTH-1:0]   fifo_data_i,
  input  logic [P_NUM_PORTS-1:0]                fifo_last_i,
  output logic [P_NUM_PORTS-1:0]                fifo_rd_o,
  output logic                                  m_valid_o,
  input  logic                                  m_ready_i,
  output logic [P_DATA_WIDTH-1:0]               m_data_o,
  output logic                                  m_last_o,
  output logic [((P_NUM_PORTS > 1) ? $clog2(P_NUM_PORTS) : 1)-1:0] m_port_o,
  output logic                                  busy_o,
  output logic                                  stall_err_o,
  input  logic                                  clr_err_i,
  output logic [15:0]                           pkt_cnt_o
);

  localparam int PW = (P_NUM_PORTS > 1) ? $clog2(P_NUM_PORTS) : 1;
  localparam int CW = $clog2(P_STALL_CYCLES + 1);

  sched_state_t             r_state;
  logic [PW-1:0]            r_grant;
  logic [PW-1:0]            r_rr_ptr;
  logic [CW-1:0]            r_stall_cnt;
  logic                     r_stall_err;
  logic [PKT_CNT_WIDTH-1:0] r_pkt_cnt;

  logic [P_NUM_PORTS-1:0]   w_req;
  logic                     w_pick_found;
  logic [PW-1:0]            w_pick_idx;
  logic                     w_head_empty;
  logic [P_DATA_WIDTH-1:0]  w_data;
  logic                     w_last;
  logic                     w_valid;
  logic                     w_hs;
  logic [P_NUM_PORTS-1:0]   w_rd;
  logic [CW-1:0]            w_stall_nxt;
  logic                     w_stall_hit;

  assign w_req = ~fifo_empty_i;

  rr_pick #(
    .P_N     (P_NUM_PORTS),
    .P_IDX_W (PW)
  ) u_rr_pick (
    .req_i   (w_req),
    .ptr_i   (r_rr_ptr),
    .found_o (w_pick_found),
    .idx_o   (w_pick_idx)
  );

  // Head-of-line mux for the granted port; outputs follow the FWFT head directly.
  always_comb begin
    w_head_empty = 1'b1;
    w_data       = '0;
    w_last       = 1'b0;
    for (int unsigned p = 0; p < P_NUM_PORTS; p++) begin
      if (r_grant == PW'(p)) begin
        w_head_empty = fifo_empty_i[p];
        w_data       = fifo_data_i[p*P_DATA_WIDTH +: P_DATA_WIDTH];
        w_last       = fifo_last_i[p];
      end
    end
    w_valid = (r_state == XFER) && !w_head_empty;
    w_hs    = w_valid && m_ready_i;
    w_rd    = '0;
    for (int unsigned p = 0; p < P_NUM_PORTS; p++) begin
      w_rd[p] = w_hs && (r_grant == PW'(p));
    end
    w_stall_nxt = (r_stall_cnt == CW'(P_STALL_CYCLES)) ? r_stall_cnt : r_stall_cnt + 1'b1;
    w_stall_hit = (r_state == XFER) && w_head_empty && (w_stall_nxt == CW'(P_STALL_CYCLES));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_stall_cnt <= '0;
      r_stall_err <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_stall_cnt <= '0;
          if (en_i && w_pick_found) begin
            r_grant  <= w_pick_idx;
            r_rr_ptr <= (w_pick_idx == PW'(P_NUM_PORTS - 1)) ? '0 : w_pick_idx + 1'b1;
            r_state  <= XFER;
          end
        end
        XFER: begin
          r_stall_cnt <= w_head_empty ? w_stall_nxt : '0;
          if (w_hs && w_last) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      if (clr_err_i) begin
        r_stall_err <= 1'b0;
      end else if (w_stall_hit) begin
        r_stall_err <= 1'b1;
      end
    end
  end

  assign fifo_rd_o   = w_rd;
  assign m_valid_o   = w_valid;
  assign m_data_o    = w_data;
  assign m_last_o    = w_last;
  assign m_port_o    = r_grant;
  assign busy_o      = (r_state == XFER);
  assign stall_err_o = r_stall_err;
  assign pkt_cnt_o   = r_pkt_cnt;

endmodule

// File: tb/tb_pkt_rr_scheduler.sv
// Bench: queue-backed FWFT sources, behavioural scheduler model, directed and random phases.
module tb_pkt_rr_scheduler;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int STALL = 8;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            en_i;
  logic [N-1:0]    fifo_empty_i;
  logic [N*DW-1:0] fifo_data_i;
  logic [N-1:0]    fifo_last_i;
  logic [N-1:0]    fifo_rd_o;
  logic            m_valid_o;
  logic            m_ready_i;
  logic [DW-1:0]   m_data_o;
  logic            m_last_o;
  logic [1:0]      m_port_o;
  logic            busy_o;
  logic            stall_err_o;
  logic            clr_err_i;
  logic [15:0]     pkt_cnt_o;

  always #5 clk_i = ~clk_i;

  pkt_rr_scheduler #(
    .P_NUM_PORTS    (N),
    .P_DATA_WIDTH   (DW),
    .P_STALL_CYCLES (STALL)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .en_i         (en_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_last_i  (fifo_last_i),
    .fifo_rd_o    (fifo_rd_o),
    .m_valid_o    (m_valid_o),
    .m_ready_i    (m_ready_i),
    .m_data_o     (m_data_o),
    .m_last_o     (m_last_o),
    .m_port_o     (m_port_o),
    .busy_o       (busy_o),
    .stall_err_o  (stall_err_o),
    .clr_err_i    (clr_err_i),
    .pkt_cnt_o    (pkt_cnt_o)
  );

  typedef struct {
    int          cyc;
    int          port;
    logic [DW-1:0] data;
    logic        last;
  } acc_t;

  logic [DW:0]  fq [N][$];
  logic [N-1:0] hide;
  acc_t         acc_log[$];

  bit m_busy;
  int m_grant, m_ptr, m_cnt, m_pkts;
  bit m_err;
  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_fifos();
    for (int p = 0; p < N; p++) begin
      if (fq[p].size() > 0 && !hide[p]) begin
        fifo_empty_i[p]           = 1'b0;
        fifo_data_i[p*DW +: DW]   = fq[p][0][DW-1:0];
        fifo_last_i[p]            = fq[p][0][DW];
      end else begin
        fifo_empty_i[p]           = 1'b1;
        fifo_data_i[p*DW +: DW]   = $urandom;
        fifo_last_i[p]            = 1'($urandom);
      end
    end
  endtask

  task automatic push_pkt(input int port, input logic [DW-1:0] base, input int len);
    for (int i = 0; i < len; i++) fq[port].push_back({(i == len - 1), base + DW'(i)});
  endtask

  task automatic flush();
    for (int p = 0; p < N; p++) fq[p].delete();
    acc_log.delete();
  endtask

  // One clock: drive at negedge, compare model against DUT, advance model after posedge.
  task automatic step(input bit en, input bit rdy, input bit clr, input logic [N-1:0] hid);
    bit [N-1:0] vis;
    bit         exp_valid;
    logic [DW:0] head;
    @(negedge clk_i);
    en_i = en; m_ready_i = rdy; clr_err_i = clr; hide = hid;
    drive_fifos();
    #1;
    for (int p = 0; p < N; p++) vis[p] = (fq[p].size() > 0) && !hid[p];
    exp_valid = m_busy && vis[m_grant];
    chk("m_valid", m_valid_o, exp_valid);
    chk("m_port", m_port_o, m_grant);
    chk("busy", busy_o, m_busy);
    chk("fifo_rd", fifo_rd_o, (exp_valid && rdy) ? (64'd1 << m_grant) : 64'd0);
    chk("stall_err", stall_err_o, m_err);
    chk("pkt_cnt", pkt_cnt_o, m_pkts % 65536);
    if (exp_valid) begin
      head = fq[m_grant][0];
      chk("m_data", m_data_o, head[DW-1:0]);
      chk("m_last", m_last_o, head[DW]);
    end
    if (m_valid_o && m_ready_i)
      acc_log.push_back('{cyc: cyc, port: int'(m_port_o), data: m_data_o, last: m_last_o});
    @(posedge clk_i);
    #1;
    if (!m_busy) begin
      m_cnt = 0;
      if (en) begin
        for (int i = 0; i < N; i++) begin
          if (!m_busy && vis[(m_ptr + i) % N]) begin
            m_grant = (m_ptr + i) % N;
            m_busy  = 1;
          end
        end
        if (m_busy) m_ptr = (m_grant + 1) % N;
      end
    end else begin
      if (!vis[m_grant]) begin
        if (m_cnt < STALL) m_cnt++;
        if (m_cnt == STALL) m_err = 1;
      end else begin
        m_cnt = 0;
      end
      if (exp_valid && rdy) begin
        head = fq[m_grant].pop_front();
        if (head[DW]) begin
          m_pkts++;
          m_busy = 0;
        end
      end
    end
    if (clr) m_err = 0;
    cyc++;
  endtask

  task automatic run_n(input int n, input bit en, input bit rdy);
    for (int i = 0; i < n; i++) step(en, rdy, 1'b0, '0);
  endtask

  // Reset is asserted between edges and checked before any clock edge occurs.
  task automatic reset_check();
    @(negedge clk_i);
    en_i = 1'($urandom); m_ready_i = 1'($urandom); clr_err_i = 1'b0;
    hide = N'($urandom);
    drive_fifos();
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_valid", m_valid_o, 0);
    chk("rst_rd", fifo_rd_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_port", m_port_o, 0);
    chk("rst_err", stall_err_o, 0);
    chk("rst_pkt", pkt_cnt_o, 0);
    m_busy = 0; m_grant = 0; m_ptr = 0; m_cnt = 0; m_err = 0; m_pkts = 0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  initial begin
    int t0;
    rst_ni = 1'b1; en_i = 1'b0; m_ready_i = 1'b0; clr_err_i = 1'b0; hide = '0;
    fifo_empty_i = '1; fifo_data_i = '0; fifo_last_i = '0;
    m_busy = 0; m_grant = 0; m_ptr = 0; m_cnt = 0; m_err = 0; m_pkts = 0;

    // Single port, 3-word packet
    reset_check(); flush();
    push_pkt(2, 32'hA0, 3);
    t0 = cyc;
    run_n(4, 1'b1, 1'b1);
    chk("p2_count", acc_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (acc_log.size() > i) begin
        chk("p2_port", acc_log[i].port, 2);
        chk("p2_data", acc_log[i].data, 32'hA0 + i);
        chk("p2_last", acc_log[i].last, (i == 2));
        chk("p2_cyc", acc_log[i].cyc, t0 + 1 + i);
      end
    end
    chk("p2_pkt_cnt", pkt_cnt_o, 1);
    acc_log.delete();
    push_pkt(0, 32'h10, 1); push_pkt(3, 32'h13, 1);
    run_n(6, 1'b1, 1'b1);
    chk("p2_ptr_count", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      chk("p2_ptr_first", acc_log[0].port, 3);
      chk("p2_ptr_second", acc_log[1].port, 0);
    end

    // All four ports, one-word packets
    reset_check(); flush();
    for (int p = 0; p < N; p++) push_pkt(p, 32'h30 + p, 1);
    t0 = cyc;
    run_n(8, 1'b1, 1'b1);
    chk("p3_count", acc_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (acc_log.size() > i) begin
        chk("p3_port", acc_log[i].port, i);
        chk("p3_cyc", acc_log[i].cyc, t0 + 1 + 2 * i);
      end
    end
    chk("p3_pkt_cnt", pkt_cnt_o, 4);

    // Backpressure mid-packet
    reset_check(); flush();
    push_pkt(1, 32'hB0, 4);
    run_n(3, 1'b1, 1'b1);
    run_n(5, 1'b1, 1'b0);
    run_n(3, 1'b1, 1'b1);
    chk("p4_count", acc_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (acc_log.size() > i) begin
        chk("p4_port", acc_log[i].port, 1);
        chk("p4_data", acc_log[i].data, 32'hB0 + i);
      end
    end

    // Starvation while granted
    reset_check(); flush();
    push_pkt(0, 32'hC0, 3);
    run_n(2, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, 4'b0001);
    chk("p5_err_before", stall_err_o, 0);
    step(1'b1, 1'b1, 1'b0, 4'b0001);
    chk("p5_err_set", stall_err_o, 1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 4'b0001);
    chk("p5_busy_held", busy_o, 1);
    run_n(4, 1'b1, 1'b1);
    chk("p5_err_sticky", stall_err_o, 1);
    chk("p5_count", acc_log.size(), 3);
    foreach (acc_log[i]) chk("p5_port", acc_log[i].port, 0);
    step(1'b1, 1'b1, 1'b1, '0);
    chk("p5_err_clr", stall_err_o, 0);

    // Enable dropped mid-packet
    reset_check(); flush();
    push_pkt(3, 32'hD0, 2);
    step(1'b1, 1'b1, 1'b0, '0);
    run_n(3, 1'b0, 1'b1);
    push_pkt(1, 32'hE1, 1); push_pkt(0, 32'hE0, 1);
    run_n(4, 1'b0, 1'b1);
    chk("p6_idle_busy", busy_o, 0);
    chk("p6_count", acc_log.size(), 2);
    acc_log.delete();
    run_n(6, 1'b1, 1'b1);
    chk("p6_resume_count", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      chk("p6_resume_first", acc_log[0].port, 0);
      chk("p6_resume_second", acc_log[1].port, 1);
    end

    // Random traffic with a mid-run asynchronous reset
    reset_check(); flush();
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] h;
      int p;
      if ($urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, N - 1);
        if (fq[p].size() < 16) push_pkt(p, $urandom, $urandom_range(1, 4));
      end
      if ((c % 400) < 12)               h = '1;
      else if ($urandom_range(0, 15) == 0) h = N'($urandom);
      else                              h = '0;
      if (c == 1500) reset_check();
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 63) == 0), h);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
